// File: rtl/plab4_net_adaptive_route_compute.sv
// Adaptive route computation for one router on a bidirectional ring.
// Chooses the previous or next direction by comparing hop distance plus a
// credit-based congestion penalty, and terminates messages addressed here.
// Keeps a saturating count of diversions, meaning valid messages sent the
// long way round because the short way was congested.
// Optional feature: define PLAB4_NET_ADAPTIVE_ROUTE_REG_OUT_EN to register
// the route output (1-cycle latency, async reset forces ROUTE_TERM).
module plab4_net_adaptive_route_compute #(
    parameter int  p_router_id   = 0,
    parameter int  p_num_routers = 8,
    localparam int c_dest_nbits  = $clog2(p_num_routers)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    val,
    input  logic [c_dest_nbits-1:0] dest,
    input  logic [1:0]              num_free_chan0,
    input  logic [1:0]              num_free_chan2,
    output logic [1:0]              route,
    output logic [7:0]              divert_count
);

    localparam logic [1:0] c_route_prev = 2'b00;
    localparam logic [1:0] c_route_next = 2'b01;
    localparam logic [1:0] c_route_term = 2'b10;

    // Worst case cost: 15 hops + 8 penalty = 23, so 5 bits never overflow.
    localparam int c_cost_nbits = 5;

    localparam logic [c_dest_nbits-1:0] c_router_id = c_dest_nbits'(p_router_id);

    // Congestion penalty from the free-credit count of one channel.
    function automatic logic [3:0] penalty(input logic [1:0] num_free);
        case (num_free)
            2'd0:    penalty = 4'd8;
            2'd1:    penalty = 4'd3;
            default: penalty = 4'd0;
        endcase
    endfunction

    logic [c_dest_nbits-1:0] hops_next;
    logic [c_dest_nbits-1:0] hops_prev;
    logic [c_cost_nbits-1:0] cost_next;
    logic [c_cost_nbits-1:0] cost_prev;
    logic [1:0]              route_dec;
    logic                    shorter_is_next;
    logic                    divert;

    // The ring size is a power of two, so plain wrap-around subtraction
    // yields the modular hop distance in each direction.
    assign hops_next = dest - c_router_id;
    assign hops_prev = c_router_id - dest;

    assign cost_next = c_cost_nbits'(hops_next) + c_cost_nbits'(penalty(num_free_chan2));
    assign cost_prev = c_cost_nbits'(hops_prev) + c_cost_nbits'(penalty(num_free_chan0));

    // Route decision: terminate locally, else take the cheaper direction.
    // Ties go to the previous direction.
    always_comb begin
        // NOTE: default assigned first so every path drives route_dec and no latch is inferred.
        route_dec = c_route_prev;
        if (dest == c_router_id) begin
            route_dec = c_route_term;
        end else if (cost_next < cost_prev) begin
            route_dec = c_route_next;
        end
    end

    // A diversion only exists when one direction is strictly shorter and
    // the decision went the other way.
    assign shorter_is_next = (hops_next < hops_prev);
    assign divert = val
                 && (route_dec != c_route_term)
                 && (hops_next != hops_prev)
                 && ((route_dec == c_route_next) != shorter_is_next);

    // Saturating diversion counter, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!reset) begin
            divert_count <= 8'd0;
        end else if (divert && (divert_count != 8'hFF)) begin
            divert_count <= divert_count + 8'd1;
        end
    end

`ifdef PLAB4_NET_ADAPTIVE_ROUTE_REG_OUT_EN
    logic [1:0] route_q;

    // Registered route output. Reset parks it on TERM so nothing is sent onward.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            route_q <= c_route_term;
        end else begin
            route_q <= route_dec;
        end
    end

    assign route = route_q;
`else
    assign route = route_dec;
`endif

endmodule

// File: tb/tb_plab4_net_adaptive_route_compute.sv
// Self-checking bench for plab4_net_adaptive_route_compute (router 2 of 8).
// A behavioural model derives route and divert_count from the ring rules;
// a negedge compare process checks every cycle, and directed vectors pin
// hand-computed expectations. Handles both builds of
// PLAB4_NET_ADAPTIVE_ROUTE_REG_OUT_EN.
module tb_plab4_net_adaptive_route_compute;

    localparam int ID = 2;
    localparam int N  = 8;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       val   = 1'b0;
    logic [2:0] dest  = 3'd0;
    logic [1:0] f0    = 2'd2;
    logic [1:0] f2    = 2'd2;
    logic [1:0] route;
    logic [7:0] divert_count;

    int vectors     = 0;
    int miscompares = 0;
    bit cmp_en      = 1'b1;

    plab4_net_adaptive_route_compute #(
        .p_router_id   (ID),
        .p_num_routers (N)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .val            (val),
        .dest           (dest),
        .num_free_chan0 (f0),
        .num_free_chan2 (f2),
        .route          (route),
        .divert_count   (divert_count)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    function automatic int pen(int free);
        if (free >= 2) return 0;
        if (free == 1) return 3;
        return 8;
    endfunction

    // 0 = PREV, 1 = NEXT, 2 = TERM
    function automatic int model_route(int d, int fr0, int fr2);
        int hn, hp;
        if (d == ID) return 2;
        hn = (d - ID + N) % N;
        hp = (ID - d + N) % N;
        return ((hn + pen(fr2)) < (hp + pen(fr0))) ? 1 : 0;
    endfunction

    function automatic bit model_divert(bit v, int d, int fr0, int fr2);
        int hn, hp, r;
        if (!v || d == ID) return 1'b0;
        hn = (d - ID + N) % N;
        hp = (ID - d + N) % N;
        if (hn == hp) return 1'b0;
        r = model_route(d, fr0, fr2);
        return (r != ((hn < hp) ? 1 : 0));
    endfunction

    int m_count   = 0;
    int m_route_q = 2;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_count   <= 0;
            m_route_q <= 2;
        end else begin
            if (model_divert(val, int'(dest), int'(f0), int'(f2)) && m_count < 255)
                m_count <= m_count + 1;
            m_route_q <= model_route(int'(dest), int'(f0), int'(f2));
        end
    end

    function automatic int exp_route();
`ifdef PLAB4_NET_ADAPTIVE_ROUTE_REG_OUT_EN
        return m_route_q;
`else
        return model_route(int'(dest), int'(f0), int'(f2));
`endif
    endfunction

    task automatic check(string name, int act, int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t dest=%0d f0=%0d f2=%0d)",
                     name, act, exp, $time, dest, f0, f2);
        end
    endtask

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("route_vs_model", int'(route), exp_route());
            check("count_vs_model", int'(divert_count), m_count);
        end
    end

    // ---------------- directed vectors ----------------
    typedef struct {
        int d;
        int a;
        int b;
        int r;
    } vec_t;

    vec_t tbl[20] = '{
        '{0, 2, 2, 0}, '{1, 2, 2, 0}, '{7, 2, 2, 0}, '{2, 2, 2, 2},
        '{3, 2, 2, 1}, '{4, 2, 2, 1}, '{5, 2, 2, 1}, '{6, 2, 2, 0},
        '{0, 0, 2, 1}, '{0, 1, 2, 0}, '{1, 0, 2, 1}, '{1, 1, 2, 0},
        '{2, 0, 2, 2}, '{3, 2, 0, 0}, '{4, 2, 0, 0}, '{5, 2, 1, 0},
        '{7, 0, 1, 1}, '{4, 0, 0, 1}, '{6, 0, 0, 0}, '{2, 0, 0, 2}
    };

    initial begin
        #2;
        check("reset_count", int'(divert_count), 0);
`ifdef PLAB4_NET_ADAPTIVE_ROUTE_REG_OUT_EN
        check("reset_route_term", int'(route), 2);
`endif
        @(posedge clk); #1;
        reset = 1'b1;

        // Routing table, val high so diversions also exercise the counter.
        val = 1'b1;
        foreach (tbl[i]) begin
            dest = 3'(tbl[i].d);
            f0   = 2'(tbl[i].a);
            f2   = 2'(tbl[i].b);
`ifdef PLAB4_NET_ADAPTIVE_ROUTE_REG_OUT_EN
            @(posedge clk); #1;
`else
            #2;
`endif
            check($sformatf("route_vec%0d", i), int'(route), tbl[i].r);
            @(posedge clk); #1;
        end

        // Statistics: fresh reset, then diversions with dest1 free0=0 (NEXT, short way is PREV).
        val  = 1'b0;
        dest = 3'd1;
        f0   = 2'd0;
        f2   = 2'd2;
        reset = 1'b0;
        #1;
        check("count_cleared", int'(divert_count), 0);
        @(posedge clk); #1;
        reset = 1'b1;
        val   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("count_after_3", int'(divert_count), 3);
        val = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("count_hold_val0", int'(divert_count), 3);
        val = 1'b1;
        repeat (300) @(posedge clk);
        #1;
        check("count_saturated", int'(divert_count), 255);

        // Asynchronous reset mid-cycle.
        @(negedge clk); #2;
        reset = 1'b0;
        #1;
        check("count_async_clear", int'(divert_count), 0);
`ifdef PLAB4_NET_ADAPTIVE_ROUTE_REG_OUT_EN
        check("route_term_in_reset", int'(route), 2);
`else
        check("route_comb_in_reset", int'(route), 1);
`endif
        repeat (2) @(posedge clk);
        #1;
        check("count_held_in_reset", int'(divert_count), 0);
        reset = 1'b0;
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("count_resume", int'(divert_count), 1);

`ifdef PLAB4_NET_ADAPTIVE_ROUTE_REG_OUT_EN
        // Registered build: new decision appears only after the next edge.
        val  = 1'b0;
        dest = 3'd2;
        f0   = 2'd2;
        f2   = 2'd2;
        @(posedge clk); #1;
        check("reg_route_term", int'(route), 2);
        dest = 3'd3;
        #2;
        check("reg_route_before_edge", int'(route), 2);
        @(posedge clk); #1;
        check("reg_route_after_edge", int'(route), 1);
`endif

        @(negedge clk); #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/plab4_net_adaptive_route_compute.md
PLAB4_NET_ADAPTIVE_ROUTE_COMPUTE -- requirements
Module: plab4_net_AdaptiveRouteCompute

Interface
REQ-001 SHALL have parameter p_router_id, default 0, index of this router on the ring (0..p_num_routers-1).
REQ-002 SHALL have parameter p_num_routers, default 8, ring size; power of two, 2..16; c_dest_nbits = $clog2(p_num_routers).
REQ-003 SHALL have port clk, input, 1, the single clock; all state on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous, active-low (0 = in reset).
REQ-005 SHALL have port val, input, 1, message valid this cycle; qualifies statistics only.
REQ-006 SHALL have port dest, input, c_dest_nbits, destination router id.
REQ-007 SHALL have port num_free_chan0, input, 2, free credits on prev-direction channel.
REQ-008 SHALL have port num_free_chan2, input, 2, free credits on next-direction channel.
REQ-009 SHALL have port route, output, 2, encoding ROUTE_PREV=2'b00, ROUTE_NEXT=2'b01, ROUTE_TERM=2'b10; 2'b11 never driven.
REQ-010 SHALL have port divert_count, output, 8, count of adaptive diversions.

Function
REQ-011 SHALL drive ROUTE_TERM whenever dest == p_router_id, regardless of credits.
REQ-012 SHALL compute hops_next = (dest - p_router_id) mod p_num_routers and hops_prev = (p_router_id - dest) mod p_num_routers.
REQ-013 SHALL compute penalty per channel from its free count: 0 for free >= 2, 3 for free = 1, 8 for free = 0.
REQ-014 SHALL compute cost_prev = hops_prev + penalty(num_free_chan0), cost_next = hops_next + penalty(num_free_chan2), in width wide enough to never overflow (>= 5 bits).
REQ-015 SHALL drive ROUTE_NEXT when cost_next < cost_prev, else ROUTE_PREV (ties, incl. both-congested ties, go PREV).
REQ-016 SHALL compute route combinationally from dest/credits (zero latency) unless REQ-024 applies.
REQ-017 SHALL define a diversion as: val=1, route not TERM, hops_prev != hops_next, and route direction differs from the strictly shorter-hop direction.
REQ-018 SHALL increment divert_count by 1 on each clock edge where a diversion occurs; saturate at 255 (no wrap).
REQ-019 SHALL leave divert_count unchanged when val=0 or no diversion.

Reset
REQ-020 SHALL clear divert_count to 0 immediately on reset assertion, independent of clk.
REQ-021 SHALL hold divert_count at 0 while reset=0; counting resumes on the first rising clk edge after deassertion.
REQ-022 SHALL not affect the combinational route path via reset (combinational build).

Configuration
REQ-023 SHALL use macro PLAB4_NET_ADAPTIVE_ROUTE_REG_OUT_EN.
REQ-024 SHALL, when the macro is defined, register route: output equals REQ-011..015 decision of the previous clk edge (1-cycle latency); reset (async) forces route = ROUTE_TERM; divert_count still uses the same-cycle decision.
REQ-025 SHALL, when the macro is undefined, produce route combinationally per REQ-016 with no route register.

Verification (p_router_id=2, p_num_routers=8, combinational build unless noted)
REQ-026 SHALL cover no congestion (free0=free2=2): dest 0,1,7 -> PREV; dest 2 -> TERM; dest 3,4,5 -> NEXT; dest 6 (4/4 tie) -> PREV.
REQ-027 SHALL cover congestion: dest0 free0=0,free2=2 -> NEXT; dest0 free0=1 -> PREV; dest1 free0=0 -> NEXT; dest1 free0=1 -> PREV; dest2 free0=0 -> TERM.
REQ-028 SHALL cover congestion: dest3/dest4 free2=0 -> PREV; dest5 free2=1 -> PREV; dest7 free0=0,free2=1 -> NEXT; both free=0 dest4 (10 vs 14) -> NEXT.
REQ-029 SHALL cover statistics: reset low then high; 3 cycles val=1 dest1 free0=0 -> divert_count=3; val=0 same inputs -> stays 3; 300 diversion cycles -> 255; reset low mid-run -> 0 immediately.
REQ-030 SHALL cover registered build: during reset route=TERM; dest3 free=2/2 applied -> route NEXT only after next rising clk edge.
